// File: rtl/add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
//   add_sub_state_e : control FSM state encoding (IDLE / RUN / DONE)
//   MODE_ADD/SUB    : encoding of the mode input
package add_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } add_sub_state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_add_sub_cell.sv
// Single-bit combinational full adder/subtractor cell.
//   a, b : operand bits
//   cin  : carry in (for subtract, the chain starts with cin=1)
//   sub  : 1 inverts b so the cell computes a + ~b + cin
//   s    : sum bit
//   cout : carry out (majority of a, effective b, cin)
module full_add_sub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic s,
    output logic cout
);

    logic b_eff;

    assign b_eff = b ^ sub;
    assign s     = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a
// single full add/sub cell with a registered carry.
//   clk, rst_n  : rising-edge clock, synchronous active-low reset
//   start       : request, taken only while ready=1
//   mode        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b        : WIDTH-bit operands (sampled with start)
//   ready       : 1 in IDLE and DONE
//   busy        : 1 in RUN
//   done        : one-cycle pulse, result and flags valid
//   result      : sum/difference mod 2^WIDTH, held until the next completion
//   carry_out   : add: carry out of MSB; sub: borrow (a < b unsigned)
//   overflow    : signed two's-complement overflow
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    add_sub_state_e state_q, state_d;

    // Operands are shifted right each RUN edge so bit 0 is always the active bit.
    logic [WIDTH-1:0] a_q, b_q;
    logic             mode_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             overflow_q;

    logic sum_bit;
    logic carry_nxt;
    logic accept;
    logic last_bit;

    full_add_sub_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sub  (mode_q),
        .s    (sum_bit),
        .cout (carry_nxt)
    );

    assign accept   = start && ready;
    assign last_bit = (state_q == S_RUN) && (cnt_q == CntW'(WIDTH - 1));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs, decoded from the state register only
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            S_IDLE: ready = 1'b1;
            S_RUN:  busy  = 1'b1;
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // New sum bit enters at the MSB end; after WIDTH shifts bit 0 lands at index 0.
    always_comb begin
        sr_d            = sr_q >> 1;
        sr_d[WIDTH-1]   = sum_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            carry_q <= mode;  // the +1 of two's-complement subtract
            cnt_q   <= '0;
        end else if (state_q == S_RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= carry_nxt;
            cnt_q   <= cnt_q + CntW'(1);
            sr_q    <= sr_d;
            if (last_bit) begin
                // On the last edge the cell sees the operand MSBs.
                result_q    <= sr_d;
                carry_out_q <= (mode_q == MODE_SUB) ? ~carry_nxt : carry_nxt;
                overflow_q  <= (a_q[0] == (b_q[0] ^ mode_q)) && (sum_bit != a_q[0]);
            end
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;
    import add_sub_pkg::*;

    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [63:0] res;
        logic        c;
        logic        v;
    } exp_t;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(int w, logic [63:0] av, logic [63:0] bv, logic m);
        exp_t   e;
        longint span = longint'(1) << w;
        longint ua   = longint'(av) & (span - 1);
        longint ub   = longint'(bv) & (span - 1);
        longint sa   = (ua >= span / 2) ? ua - span : ua;
        longint sb   = (ub >= span / 2) ? ub - span : ub;
        longint raw;
        longint sr;
        if (m == MODE_ADD) begin
            raw = ua + ub;
            e.c = (raw >= span);
            sr  = sa + sb;
        end else begin
            raw = ua - ub;
            e.c = (ua < ub);
            sr  = sa - sb;
        end
        e.res = 64'(raw & (span - 1));
        e.v   = (sr >= span / 2) || (sr < -(span / 2));
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ WIDTH=8 DUT
    logic       rst_n, start, mode;
    logic [7:0] a, b, result;
    logic       ready, busy, done, carry_out, overflow;
    exp_t       exp_q[$];
    bit         sweep_done[2];
    logic [7:0] last_res;

    serial_add_sub #(.WIDTH(W8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL w8_spurious_done: got done=1, expected no pending op (t=%0t)",
                         $time);
            end else begin
                e = exp_q.pop_front();
                check("w8_result", 64'(result), e.res);
                check("w8_carry_out", 64'(carry_out), 64'(e.c));
                check("w8_overflow", 64'(overflow), 64'(e.v));
            end
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic im);
        int guard = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) check("w8_ready_timeout", 64'(ready), 64'd1);
        a     = ia;
        b     = ib;
        mode  = im;
        start = 1'b1;
        exp_q.push_back(model(W8, 64'(ia), 64'(ib), im));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts rising edges from the caller's point until done is seen.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("w8_done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_directed(input logic [7:0] ia, input logic [7:0] ib, input logic im);
        int   lat;
        exp_t e;
        issue(ia, ib, im);
        @(negedge clk);
        check("w8_busy_in_run", 64'(busy), 64'd1);
        check("w8_hold_during_run", 64'(result), 64'(last_res));
        wait_done(lat);
        // Accept edge counted as edge 1.
        check("w8_latency", 64'(lat + 1), 64'(W8 + 1));
        e        = model(W8, 64'(ia), 64'(ib), im);
        last_res = e.res[7:0];
    endtask

    // ------------------------------------------------------------------ WIDTH=4 / 1 sweeps
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 4 : 1;

        logic          s_rst_n, s_start, s_mode;
        logic          s_ready, s_busy, s_done, s_co, s_ov;
        logic [SW-1:0] s_a, s_b, s_res;
        exp_t          s_q[$];

        serial_add_sub #(.WIDTH(SW)) u_dut (
            .clk       (clk),
            .rst_n     (s_rst_n),
            .start     (s_start),
            .mode      (s_mode),
            .a         (s_a),
            .b         (s_b),
            .ready     (s_ready),
            .busy      (s_busy),
            .done      (s_done),
            .result    (s_res),
            .carry_out (s_co),
            .overflow  (s_ov)
        );

        always @(negedge clk) begin
            exp_t e;
            if (s_done === 1'b1) begin
                if (s_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL w%0d_spurious_done: got done=1, expected none", SW);
                end else begin
                    e = s_q.pop_front();
                    check($sformatf("w%0d_result", SW), 64'(s_res), e.res);
                    check($sformatf("w%0d_carry_out", SW), 64'(s_co), 64'(e.c));
                    check($sformatf("w%0d_overflow", SW), 64'(s_ov), 64'(e.v));
                end
            end
        end

        initial begin
            int guard;
            s_rst_n = 1'b0;
            s_start = 1'b0;
            s_mode  = 1'b0;
            s_a     = '0;
            s_b     = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            s_rst_n = 1'b1;
            for (int m = 0; m < 2; m++) begin
                for (int x = 0; x < (1 << SW); x++) begin
                    for (int y = 0; y < (1 << SW); y++) begin
                        guard = 0;
                        @(negedge clk);
                        while (s_ready !== 1'b1 && guard < 50) begin
                            @(negedge clk);
                            guard++;
                        end
                        if (s_ready !== 1'b1)
                            check($sformatf("w%0d_ready_timeout", SW), 64'(s_ready), 64'd1);
                        s_a     = SW'(x);
                        s_b     = SW'(y);
                        s_mode  = m[0];
                        s_start = 1'b1;
                        s_q.push_back(model(SW, 64'(x), 64'(y), m[0]));
                        @(posedge clk);
                        #1 s_start = 1'b0;
                    end
                end
            end
            guard = 0;
            while (s_q.size() != 0 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("w%0d_drain", SW), 64'(s_q.size()), 64'd0);
            sweep_done[g] = 1'b1;
        end
    end

    // ------------------------------------------------------------------ main sequence
    initial begin
        int   lat;
        int   guard;
        bit   seen;
        exp_t e;

        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        a        = '0;
        b        = '0;
        last_res = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_carry_out", 64'(carry_out), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;

        // Carry, borrow and signed-overflow corners
        run_directed(8'hFF, 8'h01, MODE_ADD);
        run_directed(8'h05, 8'h07, MODE_SUB);
        run_directed(8'h07, 8'h05, MODE_SUB);
        run_directed(8'h7F, 8'h01, MODE_ADD);
        run_directed(8'h80, 8'h01, MODE_SUB);

        // start pulsed mid-RUN with new operands must be ignored
        issue(8'h3C, 8'h15, MODE_ADD);
        repeat (2) @(posedge clk);
        #1;
        a     = 8'hAA;
        b     = 8'h55;
        mode  = MODE_SUB;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("w8_busy_mid_run", 64'(busy), 64'd1);
        check("w8_ready_mid_run", 64'(ready), 64'd0);
        check("w8_hold_mid_run", 64'(result), 64'(last_res));
        wait_done(lat);

        // start held high: second op launches straight out of DONE
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        mode  = MODE_ADD;
        start = 1'b1;
        exp_q.push_back(model(W8, 64'h10, 64'h20, MODE_ADD));
        @(posedge clk);
        #1;
        a    = 8'h90;
        b    = 8'h20;
        mode = MODE_SUB;
        exp_q.push_back(model(W8, 64'h90, 64'h20, MODE_SUB));
        wait_done(lat);
        check("w8_b2b_latency1", 64'(lat + 1), 64'(W8 + 1));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check("w8_b2b_latency2", 64'(lat + 1), 64'(W8 + 1));
        e        = model(W8, 64'h90, 64'h20, MODE_SUB);
        last_res = e.res[7:0];

        // Reset in the middle of RUN discards the operation
        issue(8'h12, 8'h34, MODE_ADD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_carry_out", 64'(carry_out), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        last_res = '0;
        run_directed(8'hC8, 8'h64, MODE_SUB);

        // Random back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("w8_drain", 64'(exp_q.size()), 64'd0);

        guard = 0;
        while (!(sweep_done[0] && sweep_done[1]) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("sweeps_complete", 64'(sweep_done[0] && sweep_done[1]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
